// File: rtl/cv32e40p_x_mem_arbiter.sv
// cv32e40p_x_mem_arbiter: round-robin N-channel X-interface memory arbiter with in-order response routing.
// Define CV32E40P_X_MEM_ARB_PERF_EN to build the saturating grant-stall counter behind perf_stall_cnt_o.
module cv32e40p_x_mem_arbiter #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  ch_req_valid_i,
  output logic [NUM_CH-1:0]                  ch_req_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]       ch_req_addr_i,
  input  logic [NUM_CH*2-1:0]                ch_req_type_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       ch_req_wdata_i,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]   ch_req_be_i,
  output logic [NUM_CH-1:0]                  ch_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]              ch_rsp_rdata_o,
  output logic                               ch_rsp_err_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic                               mem_we_o,
  output logic [1:0]                         mem_type_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  input  logic                               mem_err_i,
  output logic [31:0]                        perf_stall_cnt_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [1:0]  TYPE_WRITE = 2'b01;

  logic [CH_W-1:0]  rr_ptr_r;
  logic [CH_W-1:0]  lock_ch_r;
  logic             lock_r;
  logic [CH_W-1:0]  sel_s;
  logic [CH_W-1:0]  cand_s;
  logic [CH_W-1:0]  head_ch_s;
  logic             any_sel_s;
  logic             full_s;
  logic             req_s;
  logic             grant_s;
  logic             rsp_fire_s;
  logic [CH_W-1:0]  fifo_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  // Select the locked channel, otherwise the first valid channel at or after rr_ptr_r.
  always_comb begin
    sel_s     = '0;
    cand_s    = '0;
    any_sel_s = 1'b0;
    if (lock_r) begin
      sel_s     = lock_ch_r;
      any_sel_s = ch_req_valid_i[lock_ch_r];
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cand_s    = CH_W'((32'(rr_ptr_r) + i) % NUM_CH);
        sel_s     = (!any_sel_s && ch_req_valid_i[cand_s]) ? cand_s : sel_s;
        any_sel_s = any_sel_s | ch_req_valid_i[cand_s];
      end
    end
  end

  // A full ID FIFO blocks new requests even when a response retires an entry this cycle.
  assign full_s     = (count_r == CNT_W'(MAX_OUTSTANDING));
  assign req_s      = any_sel_s & ~full_s;
  assign grant_s    = req_s & mem_gnt_i;
  assign rsp_fire_s = mem_rvalid_i & (count_r != CNT_W'(0));
  assign head_ch_s  = fifo_mem_r[head_r];

  assign mem_req_o   = req_s;
  assign mem_addr_o  = req_s ? ch_req_addr_i[32'(sel_s)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_type_o  = req_s ? ch_req_type_i[32'(sel_s)*2 +: 2] : 2'b00;
  assign mem_we_o    = req_s & (mem_type_o == TYPE_WRITE);
  assign mem_wdata_o = req_s ? ch_req_wdata_i[32'(sel_s)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mem_be_o    = req_s ? ch_req_be_i[32'(sel_s)*BE_W +: BE_W] : '0;

  // Decode the granted channel and the response owner into one-hot strobes.
  always_comb begin
    ch_req_ready_o = '0;
    ch_rsp_valid_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_req_ready_o[k] = grant_s & (sel_s == CH_W'(k));
      ch_rsp_valid_o[k] = rsp_fire_s & (head_ch_s == CH_W'(k));
    end
  end

  assign ch_rsp_rdata_o = rsp_fire_s ? mem_rdata_i : '0;
  assign ch_rsp_err_o   = rsp_fire_s & mem_err_i;

  // Round-robin pointer and lock: an ungranted request pins its channel until granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r  <= '0;
      lock_r    <= 1'b0;
      lock_ch_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r  <= (sel_s == CH_W'(NUM_CH - 1)) ? CH_W'(0) : sel_s + CH_W'(1);
      lock_r    <= 1'b0;
    end else if (req_s) begin
      lock_r    <= 1'b1;
      lock_ch_r <= sel_s;
    end
  end

  // In-order ID FIFO of granted channels; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (grant_s) begin
        fifo_mem_r[tail_r] <= sel_s;
        tail_r             <= tail_r + PTR_W'(1);
      end
      if (rsp_fire_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({grant_s, rsp_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef CV32E40P_X_MEM_ARB_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where a request waits for grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0;
    end else if (req_s && !mem_gnt_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_r;
`else
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule
